// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// MEM-stage data-memory access unit. Converts the EX/MEM address, store data
// and funct3 into a single req/ack data-memory transaction. Produces the
// extended load value for MEM_to_WB. Stalls the pipeline while the access is
// outstanding.
//
// Parameters
//   TIMEOUT_CYCLES : max BUSY cycles without dmem_ack before the access is abandoned (>=1)
//   CNT_W          : timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Optional feature macro
//   MEM_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses skip the
//                          bus and flag misaligned_MEM in the DONE cycle.
//                          When undefined, misaligned_MEM is tied 0 and the
//                          low address bits are ignored for half/word accesses.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   valid_MEM           : valid instruction in MEM
//   mem_read_MEM        : load
//   mem_write_MEM       : store (wins if both read and write are set)
//   funct3_MEM          : RV32I load/store size/sign encoding
//   ALU_result_MEM      : effective byte address
//   write_data_MEM      : right-aligned store data
//   dmem_req/we/addr/wdata/be : registered memory request, held for all of BUSY
//   dmem_ack, dmem_rdata : memory completion pulse and read word
//   read_data_MEM       : registered, extended load result
//   mem_stall           : combinational pipeline stall
//   bus_err_MEM         : timeout flag, high only in the DONE cycle
//   misaligned_MEM      : misalignment trap flag, high only in the DONE cycle
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_MEM,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] ALU_result_MEM,
  input  logic [31:0] write_data_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data_MEM,
  output logic        mem_stall,
  output logic        bus_err_MEM,
  output logic        misaligned_MEM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic             access;
  logic             misaligned;
  logic             expire;
  logic             start_busy;
  logic [CNT_W-1:0] timeout_cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [31:0]      load_value;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign access = valid_MEM & (mem_read_MEM | mem_write_MEM);

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers the undefined 011/110/111).
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((funct3_MEM[1:0] == 2'b01) & ALU_result_MEM[0]) |
                      (funct3_MEM[1] & (ALU_result_MEM[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Reaching TIMEOUT_CYCLES-1 in a BUSY cycle means this is the last allowed cycle.
  assign expire     = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign start_busy = (state == IDLE) & access & ~misaligned;
  assign mem_stall  = ((state == IDLE) & access) | (state == BUSY);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (access) state_next = misaligned ? DONE : BUSY;
      BUSY: if (dmem_ack || expire) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Lane placement for stores; half ignores addr[0] so the unaligned case
  // behaves as aligned when the trap is disabled.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = write_data_MEM;
    case (funct3_MEM[1:0])
      2'b00: begin
        be_next    = 4'b0001 << ALU_result_MEM[1:0];
        wdata_next = {4{write_data_MEM[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {ALU_result_MEM[1], 1'b0};
        wdata_next = {2{write_data_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction uses the funct3/offset captured at request time.
  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (off_q)
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      2'd3:    byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_value = dmem_rdata;
    case (funct3_q)
      3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_value = {24'd0, byte_sel};
      3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_value = {16'd0, half_sel};
      default: load_value = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_wdata  <= 32'd0;
      dmem_be     <= 4'd0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      timeout_cnt <= '0;
    end else if (start_busy) begin
      dmem_req    <= 1'b1;
      dmem_we     <= mem_write_MEM;
      dmem_addr   <= {ALU_result_MEM[31:2], 2'b00};
      dmem_wdata  <= wdata_next;
      dmem_be     <= be_next;
      funct3_q    <= funct3_MEM;
      off_q       <= ALU_result_MEM[1:0];
      timeout_cnt <= '0;
    end else if (state == BUSY) begin
      if (dmem_ack || expire) dmem_req <= 1'b0;
      else                    timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  // Status flags are set on the edge entering DONE and drop on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_MEM    <= 1'b0;
      misaligned_MEM <= 1'b0;
      read_data_MEM  <= 32'd0;
    end else begin
      bus_err_MEM    <= (state == BUSY) & ~dmem_ack & expire;
      misaligned_MEM <= (state == IDLE) & access & misaligned;
      if (state == BUSY && dmem_ack)
        read_data_MEM <= dmem_we ? 32'd0 : load_value;
      else if ((state == BUSY && expire) || ((state == IDLE) && access && misaligned))
        read_data_MEM <= 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// -------------------
// Directed bench for mem_access_stage with TIMEOUT_CYCLES=4. Each access is
// driven in IDLE, a memory model answers after a chosen number of BUSY cycles
// (0 = never), and the request fields, stall profile and DONE-cycle results
// are compared against hand-computed values.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_MEM;
  logic        mem_read_MEM;
  logic        mem_write_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] ALU_result_MEM;
  logic [31:0] write_data_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data_MEM;
  logic        mem_stall;
  logic        bus_err_MEM;
  logic        misaligned_MEM;

  int checkCount;
  int errorCount;

  // Observations of the last access
  int          busyCycles;
  int          stallCount;
  logic        obsWe;
  logic [31:0] obsAddr;
  logic [31:0] obsWdata;
  logic [3:0]  obsBe;
  logic        doneStall;
  logic        doneErr;
  logic        doneMis;
  logic [31:0] doneData;
  logic [31:0] holdData;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .valid_MEM(valid_MEM),
    .mem_read_MEM(mem_read_MEM),
    .mem_write_MEM(mem_write_MEM),
    .funct3_MEM(funct3_MEM),
    .ALU_result_MEM(ALU_result_MEM),
    .write_data_MEM(write_data_MEM),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .read_data_MEM(read_data_MEM),
    .mem_stall(mem_stall),
    .bus_err_MEM(bus_err_MEM),
    .misaligned_MEM(misaligned_MEM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one access starting just after a rising edge with the DUT in IDLE,
  // answers with rdata after ackAfter BUSY cycles (0 = never) and records
  // the request fields, stall profile and DONE-cycle outputs.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdata, input int ackAfter);
    int guard;
    valid_MEM      = 1'b1;
    mem_read_MEM   = rd;
    mem_write_MEM  = wr;
    funct3_MEM     = f3;
    ALU_result_MEM = addr;
    write_data_MEM = wd;
    #1;
    stallCount = mem_stall ? 1 : 0;
    @(posedge clk); #1;
    valid_MEM     = 1'b0;
    mem_read_MEM  = 1'b0;
    mem_write_MEM = 1'b0;
    obsWe    = dmem_we;
    obsAddr  = dmem_addr;
    obsWdata = dmem_wdata;
    obsBe    = dmem_be;
    busyCycles = 0;
    guard = 0;
    while (dmem_req && guard < 50) begin
      guard++;
      busyCycles++;
      if (mem_stall) stallCount++;
      if (busyCycles == ackAfter) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
    end
    doneStall = mem_stall;
    doneErr   = bus_err_MEM;
    doneMis   = misaligned_MEM;
    doneData  = read_data_MEM;
    @(posedge clk); #1;
    holdData = read_data_MEM;
  endtask

  task automatic checkAccess(input string name, input int expBusy, input logic [31:0] expData,
                             input logic expErr, input logic expMis);
    checkOutput({name, ".busy"},      32'(busyCycles), 32'(expBusy));
    checkOutput({name, ".stall"},     32'(stallCount), 32'(expBusy + 1));
    checkOutput({name, ".doneStall"}, {31'd0, doneStall}, 32'd0);
    checkOutput({name, ".data"},      doneData, expData);
    checkOutput({name, ".err"},       {31'd0, doneErr}, {31'd0, expErr});
    checkOutput({name, ".mis"},       {31'd0, doneMis}, {31'd0, expMis});
    checkOutput({name, ".hold"},      holdData, expData);
  endtask

  task automatic checkRequest(input string name, input logic expWe, input logic [31:0] expAddr,
                              input logic [31:0] expWdata, input logic [3:0] expBe);
    checkOutput({name, ".we"},    {31'd0, obsWe}, {31'd0, expWe});
    checkOutput({name, ".addr"},  obsAddr, expAddr);
    checkOutput({name, ".wdata"}, obsWdata, expWdata);
    checkOutput({name, ".be"},    {28'd0, obsBe}, {28'd0, expBe});
  endtask

  initial begin
    checkCount     = 0;
    errorCount     = 0;
    rst            = 1'b0;
    valid_MEM      = 1'b0;
    mem_read_MEM   = 1'b0;
    mem_write_MEM  = 1'b0;
    funct3_MEM     = 3'd0;
    ALU_result_MEM = 32'd0;
    write_data_MEM = 32'd0;
    dmem_ack       = 1'b0;
    dmem_rdata     = 32'd0;

    #12;
    checkOutput("reset.req",   {31'd0, dmem_req}, 32'd0);
    checkOutput("reset.addr",  dmem_addr, 32'd0);
    checkOutput("reset.be",    {28'd0, dmem_be}, 32'd0);
    checkOutput("reset.data",  read_data_MEM, 32'd0);
    checkOutput("reset.stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("reset.err",   {31'd0, bus_err_MEM}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic word load, one-cycle memory
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1);
    checkAccess("lw", 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checkRequest("lw", 1'b0, 32'h0000_0100, 32'd0, 4'b1111);

    // Sub-word load extraction
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 1);
    checkAccess("lb", 1, 32'hFFFF_FF80, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 1);
    checkAccess("lbu", 1, 32'h0000_0080, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h80FF_FF7F, 1);
    checkAccess("lh", 1, 32'hFFFF_80FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'd0, 32'h80FF_FF7F, 2);
    checkAccess("lhu", 2, 32'h0000_FF7F, 1'b0, 1'b0);

    // Stores: lane replication and byte enables; stores load 0
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_5678, 32'hFFFF_FFFF, 1);
    checkAccess("sb", 1, 32'd0, 1'b0, 1'b0);
    checkRequest("sb", 1'b1, 32'h0000_0100, 32'h7878_7878, 4'b0010);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_5678, 32'd0, 1);
    checkRequest("sh", 1'b1, 32'h0000_0100, 32'h5678_5678, 4'b1100);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 32'd0, 1);
    checkRequest("rdwr_sw", 1'b1, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111);

    // Timeout boundary: ack on the last allowed cycle wins, no ack expires
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_010C, 32'd0, 32'h1357_9BDF, 4);
    checkAccess("ack_at_limit", 4, 32'h1357_9BDF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_010C, 32'd0, 32'h1357_9BDF, 0);
    checkAccess("timeout", 4, 32'd0, 1'b1, 1'b0);

    // Undefined funct3 011 behaves as LW
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0110, 32'd0, 32'h0BAD_F00D, 1);
    checkAccess("f3_011", 1, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Reset in the middle of BUSY, then a stray ack
    valid_MEM      = 1'b1;
    mem_read_MEM   = 1'b1;
    funct3_MEM     = 3'b010;
    ALU_result_MEM = 32'h0000_0200;
    @(posedge clk); #1;
    valid_MEM    = 1'b0;
    mem_read_MEM = 1'b0;
    checkOutput("rst.busyReq", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst.req",   {31'd0, dmem_req}, 32'd0);
    checkOutput("rst.stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("rst.data",  read_data_MEM, 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    checkOutput("lateAck.req",   {31'd0, dmem_req}, 32'd0);
    checkOutput("lateAck.stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("lateAck.data",  read_data_MEM, 32'd0);
    @(posedge clk); #1;
    checkOutput("lateAck.err",   {31'd0, bus_err_MEM}, 32'd0);

    // Undefined funct3 110 after reset: back to normal operation
    applyStimulus(1'b1, 1'b0, 3'b110, 32'h0000_0114, 32'd0, 32'h1122_3344, 1);
    checkAccess("f3_110", 1, 32'h1122_3344, 1'b0, 1'b0);

    // Misaligned word
`ifdef MEM_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'h7654_3210, 1);
    checkAccess("misLw", 0, 32'd0, 1'b0, 1'b1);
    checkOutput("misLw.misAfter", {31'd0, misaligned_MEM}, 32'd0);
`else
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'h7654_3210, 1);
    checkAccess("misLw", 1, 32'h7654_3210, 1'b0, 1'b0);
    checkOutput("misLw.addr", obsAddr, 32'h0000_0100);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
